// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS main control FSM.
package mips_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECUTE  = 4'd6,
    ST_ALUWB    = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_ADDIEX   = 4'd9,
    ST_ADDIWB   = 4'd10,
    ST_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Datapath control bundle; pc_write and branch are merged with zero by the top.
  typedef struct packed {
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_write;
    logic       branch;
    logic       i_or_d;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    logic legal;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// State-to-control decode: Moore outputs, with fetch strobes gated by memory ready.
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_src    = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      ST_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      ST_MEMREAD: ctrl_o.i_or_d = 1'b1;
      ST_MEMWB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      ST_MEMWRITE: begin
        ctrl_o.i_or_d    = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      ST_EXECUTE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_src    = PCSRC_ALUOUT;
        ctrl_o.branch    = 1'b1;
      end
      ST_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      ST_ADDIWB: ctrl_o.reg_write = 1'b1;
      ST_JUMP: begin
        ctrl_o.pc_src   = PCSRC_JUMP;
        ctrl_o.pc_write = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control: state register, opcode-driven sequencing and PC enable.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_t state_q, state_d;
  ctrl_t  ctrl;
  logic   ready;

  assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  mips_ctrl_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (ready),
    .ctrl_o      (ctrl)
  );

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH: state_d = ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXECUTE;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ST_FETCH;
        endcase
      end
      // A non-memory opcode here means the IR was disturbed; abandon the instruction.
      ST_MEMADR: begin
        if (opcode == OP_LW)      state_d = ST_MEMREAD;
        else if (opcode == OP_SW) state_d = ST_MEMWRITE;
        else                      state_d = ST_FETCH;
      end
      ST_MEMREAD:  state_d = ready ? ST_MEMWB : ST_MEMREAD;
      ST_MEMWB:    state_d = ST_FETCH;
      ST_MEMWRITE: state_d = ready ? ST_FETCH : ST_MEMWRITE;
      ST_EXECUTE:  state_d = ST_ALUWB;
      ST_ALUWB:    state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
      ST_ADDIEX:   state_d = ST_ADDIWB;
      ST_ADDIWB:   state_d = ST_FETCH;
      ST_JUMP:     state_d = ST_FETCH;
      default:     state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // Strobes are masked by rst_n so FETCH's mem_ready-driven writes stay quiet in reset.
  assign mem_write  = rst_n & ctrl.mem_write;
  assign ir_write   = rst_n & ctrl.ir_write;
  assign reg_write  = rst_n & ctrl.reg_write;
  assign pc_en      = rst_n & (ctrl.pc_write | (ctrl.branch & zero));
  assign illegal_op = rst_n & (state_q == ST_DECODE) & ~is_legal_op(opcode);

  assign i_or_d     = ctrl.i_or_d;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_dst    = ctrl.reg_dst;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign pc_src     = ctrl.pc_src;
  assign alu_op     = ctrl.alu_op;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl with an instruction-level reference model.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_SW    = 6'b101011;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_ADDI  = 6'b001000;
  localparam logic [5:0] T_J     = 6'b000010;

  typedef struct packed {
    logic       mw;
    logic       irw;
    logic       rw;
    logic       pce;
    logic       iod;
    logic       m2r;
    logic       rd;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] ps;
    logic [1:0] ao;
    logic       ill;
  } obs_t;

  // Clock/reset and DUT inputs
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic       mem_write, ir_write, reg_write, pc_en, i_or_d, mem_to_reg, reg_dst, alu_src_a;
  logic [1:0] alu_src_b, pc_src, alu_op;
  logic       illegal_op;
  logic [3:0] state_dbg;

  logic       nw_mem_write, nw_ir_write, nw_reg_write, nw_pc_en, nw_i_or_d, nw_mem_to_reg;
  logic       nw_reg_dst, nw_alu_src_a;
  logic [1:0] nw_alu_src_b, nw_pc_src, nw_alu_op;
  logic       nw_illegal_op;
  logic [3:0] nw_state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write), .pc_en(pc_en),
    .i_or_d(i_or_d), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
  );

  mips_multicycle_ctrl #(.MEM_WAIT_EN(1'b0)) dut_nw (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_write(nw_mem_write), .ir_write(nw_ir_write), .reg_write(nw_reg_write),
    .pc_en(nw_pc_en), .i_or_d(nw_i_or_d), .mem_to_reg(nw_mem_to_reg), .reg_dst(nw_reg_dst),
    .alu_src_a(nw_alu_src_a), .alu_src_b(nw_alu_src_b), .pc_src(nw_pc_src),
    .alu_op(nw_alu_op), .illegal_op(nw_illegal_op), .state_dbg(nw_state_dbg)
  );

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {T_RTYPE, T_LW, T_SW, T_BEQ, T_ADDI, T_J};
  endfunction

  // Output table straight from the state descriptions (state number, ready, zero, opcode).
  function automatic obs_t exp_vec(input int st, input bit rdy, input bit z, input logic [5:0] op);
    obs_t e;
    e = '0;
    case (st)
      0:  begin e.sb = 2'b01; e.irw = rdy; e.pce = rdy; end
      1:  begin e.sb = 2'b11; e.ill = !is_legal(op); end
      2:  begin e.sa = 1'b1; e.sb = 2'b10; end
      3:  e.iod = 1'b1;
      4:  begin e.m2r = 1'b1; e.rw = 1'b1; end
      5:  begin e.iod = 1'b1; e.mw = 1'b1; end
      6:  begin e.sa = 1'b1; e.ao = 2'b10; end
      7:  begin e.rd = 1'b1; e.rw = 1'b1; end
      8:  begin e.sa = 1'b1; e.ao = 2'b01; e.ps = 2'b01; e.pce = z; end
      9:  begin e.sa = 1'b1; e.sb = 2'b10; end
      10: e.rw = 1'b1;
      11: begin e.ps = 2'b10; e.pce = 1'b1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic obs_t obs(input bit nw);
    obs_t o;
    if (nw)
      o = {nw_mem_write, nw_ir_write, nw_reg_write, nw_pc_en, nw_i_or_d, nw_mem_to_reg,
           nw_reg_dst, nw_alu_src_a, nw_alu_src_b, nw_pc_src, nw_alu_op, nw_illegal_op};
    else
      o = {mem_write, ir_write, reg_write, pc_en, i_or_d, mem_to_reg,
           reg_dst, alu_src_a, alu_src_b, pc_src, alu_op, illegal_op};
    return o;
  endfunction

  // Driver plus scoreboard for one instruction. Time is in the low clock phase on entry
  // and exit; with stop_at >= 0 it returns right after sampling that cycle.
  task automatic run_instr(input string name, input logic [5:0] op, input bit z,
                           input int fw, input int mw, input bit nw, input int stop_at);
    logic [3:0] exp_q[$];
    bit         rdy_q[$];
    int         fwe, mwe, n_ir, n_pc, n_mw, n_rw, exp_pc, exp_mw, exp_rw;
    logic [3:0] obs_st;
    obs_t       ov, ev;
    fwe = nw ? 0 : fw;
    mwe = nw ? 0 : mw;
    n_ir = 0; n_pc = 0; n_mw = 0; n_rw = 0;
    repeat (fwe) begin exp_q.push_back(4'd0); rdy_q.push_back(1'b0); end
    exp_q.push_back(4'd0); rdy_q.push_back(1'b1);
    exp_q.push_back(4'd1); rdy_q.push_back(1'b1);
    case (op)
      T_LW: begin
        exp_q.push_back(4'd2); rdy_q.push_back(1'b1);
        repeat (mwe) begin exp_q.push_back(4'd3); rdy_q.push_back(1'b0); end
        exp_q.push_back(4'd3); rdy_q.push_back(1'b1);
        exp_q.push_back(4'd4); rdy_q.push_back(1'b1);
      end
      T_SW: begin
        exp_q.push_back(4'd2); rdy_q.push_back(1'b1);
        repeat (mwe) begin exp_q.push_back(4'd5); rdy_q.push_back(1'b0); end
        exp_q.push_back(4'd5); rdy_q.push_back(1'b1);
      end
      T_RTYPE: begin
        exp_q.push_back(4'd6); rdy_q.push_back(1'b1);
        exp_q.push_back(4'd7); rdy_q.push_back(1'b1);
      end
      T_BEQ: begin exp_q.push_back(4'd8); rdy_q.push_back(1'b1); end
      T_ADDI: begin
        exp_q.push_back(4'd9);  rdy_q.push_back(1'b1);
        exp_q.push_back(4'd10); rdy_q.push_back(1'b1);
      end
      T_J: begin exp_q.push_back(4'd11); rdy_q.push_back(1'b1); end
      default: ;
    endcase

    for (int i = 0; i < exp_q.size(); i++) begin
      opcode    = op;
      zero      = z;
      mem_ready = nw ? 1'b0 : rdy_q[i];
      #1;
      obs_st = nw ? nw_state_dbg : state_dbg;
      ov     = obs(nw);
      ev     = exp_vec(int'(exp_q[i]), rdy_q[i], z, op);
      n_tests++;
      if (obs_st !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s state cyc%0d: got %0d exp %0d", name, i, obs_st, exp_q[i]);
      end
      n_tests++;
      if (ov !== ev) begin
        n_fail++;
        $display("FAIL %s outputs cyc%0d st%0d: got %h exp %h", name, i, exp_q[i], ov, ev);
      end
      n_ir += int'(ov.irw);
      n_pc += int'(ov.pce);
      n_mw += int'(ov.mw);
      n_rw += int'(ov.rw);
      if (i == stop_at) return;
      @(negedge clk);
    end

    obs_st = nw ? nw_state_dbg : state_dbg;
    n_tests++;
    if (obs_st !== 4'd0) begin
      n_fail++;
      $display("FAIL %s end_state: got %0d exp 0", name, obs_st);
    end
    exp_pc = 1 + ((op == T_J) ? 1 : 0) + ((op == T_BEQ && z) ? 1 : 0);
    exp_mw = (op == T_SW) ? mwe + 1 : 0;
    exp_rw = (op == T_LW || op == T_RTYPE || op == T_ADDI) ? 1 : 0;
    n_tests++;
    if (n_ir != 1) begin
      n_fail++;
      $display("FAIL %s ir_write_count: got %0d exp 1", name, n_ir);
    end
    n_tests++;
    if (n_pc != exp_pc) begin
      n_fail++;
      $display("FAIL %s pc_en_count: got %0d exp %0d", name, n_pc, exp_pc);
    end
    n_tests++;
    if (n_mw != exp_mw) begin
      n_fail++;
      $display("FAIL %s mem_write_count: got %0d exp %0d", name, n_mw, exp_mw);
    end
    n_tests++;
    if (n_rw != exp_rw) begin
      n_fail++;
      $display("FAIL %s reg_write_count: got %0d exp %0d", name, n_rw, exp_rw);
    end
  endtask

  task automatic test_reset();
    obs_t ev;
    rst_n = 1'b0; mem_ready = 1'b1; opcode = T_RTYPE; zero = 1'b1;
    ev = exp_vec(0, 1'b0, 1'b0, T_RTYPE);
    #2;
    n_tests++;
    if (state_dbg !== 4'd0 || obs(1'b0) !== ev) begin
      n_fail++;
      $display("FAIL reset_outputs: got st%0d %h exp st0 %h", state_dbg, obs(1'b0), ev);
    end
    @(negedge clk); #1;
    n_tests++;
    if (state_dbg !== 4'd0 || obs(1'b0) !== ev) begin
      n_fail++;
      $display("FAIL reset_hold: got st%0d %h exp st0 %h", state_dbg, obs(1'b0), ev);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    run_instr("rtype", T_RTYPE, 1'b0, 0, 0, 1'b0, -1);
  endtask

  task automatic test_lw_waits();
    run_instr("lw_waits", T_LW, 1'b0, 2, 1, 1'b0, -1);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", T_BEQ, 1'b1, 0, 0, 1'b0, -1);
    run_instr("beq_not_taken", T_BEQ, 1'b0, 0, 0, 1'b0, -1);
  endtask

  task automatic test_sw_waits();
    run_instr("sw_waits", T_SW, 1'b0, 0, 3, 1'b0, -1);
  endtask

  task automatic test_illegal();
    run_instr("illegal", 6'b111111, 1'b0, 0, 0, 1'b0, -1);
    run_instr("jump", T_J, 1'b0, 0, 0, 1'b0, -1);
  endtask

  task automatic test_reset_mid_addi();
    obs_t ev;
    run_instr("addi_abort", T_ADDI, 1'b0, 0, 0, 1'b0, 2);
    #2;
    rst_n = 1'b0;
    #1;
    ev = exp_vec(0, 1'b0, 1'b0, T_ADDI);
    n_tests++;
    if (state_dbg !== 4'd0 || obs(1'b0) !== ev) begin
      n_fail++;
      $display("FAIL async_reset: got st%0d %h exp st0 %h", state_dbg, obs(1'b0), ev);
    end
    repeat (2) begin
      @(negedge clk); #1;
      n_tests++;
      if (state_dbg !== 4'd0 || reg_write !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_regwrite: got st%0d rw%0b exp st0 rw0", state_dbg, reg_write);
      end
    end
    rst_n = 1'b1;
    run_instr("addi_after_reset", T_ADDI, 1'b0, 0, 0, 1'b0, -1);
  endtask

  task automatic test_no_wait();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    run_instr("nw_lw", T_LW, 1'b0, 2, 2, 1'b1, -1);
    run_instr("nw_sw", T_SW, 1'b0, 1, 3, 1'b1, -1);
    run_instr("nw_beq", T_BEQ, 1'b1, 1, 0, 1'b1, -1);
    run_instr("nw_rtype", T_RTYPE, 1'b0, 3, 0, 1'b1, -1);
  endtask

  task automatic test_random();
    logic [5:0] ops[6];
    logic [5:0] op;
    ops[0] = T_RTYPE; ops[1] = T_LW; ops[2] = T_SW;
    ops[3] = T_BEQ;   ops[4] = T_ADDI; ops[5] = T_J;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 6) == 0) begin
        op = 6'($urandom_range(0, 63));
        while (is_legal(op)) op = 6'($urandom_range(0, 63));
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      run_instr("random", op, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'b0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_waits();
    test_beq();
    test_sw_waits();
    test_illegal();
    test_reset_mid_addi();
    test_no_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
